cix32_prefetch_queue: RTL



---
 rtl/cix32_prefetch_queue.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cix32_prefetch_queue.sv
// Instruction prefetch byte queue: fetches aligned 32-bit words into a circular
// byte buffer and offers a window of up to 15 bytes to the x86 decoder.
module cix32_prefetch_queue #(
   parameter int unsigned DEPTH_BYTES = 32,
   parameter int unsigned MIN_WINDOW  = 15,
   parameter logic [31:0] RESET_EIP   = 32'hFFFF_FFF0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic [31:0]  flush_eip,
   output logic         fetch_req,
   output logic [31:0]  fetch_addr,
   input  logic         fetch_ack,
   input  logic [31:0]  fetch_data,
   output logic [127:0] bytes_out,
   output logic [3:0]   valid_bytes,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_eip,
   input  logic         consume_valid,
   input  logic [3:0]   consume_len,
   output logic         underflow_err
);
   localparam int PW = $clog2(DEPTH_BYTES);
   localparam int CW = PW + 1;

   typedef enum logic {ST_PRESENT, ST_WAIT_CONSUME} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [7:0]    r_mem [DEPTH_BYTES];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          r_fetch_req;
   logic          r_drop_pending;
   logic          r_underflow;
   logic [31:0]   r_fetch_addr;
   logic [31:0]   r_out_eip;
   logic [1:0]    r_skip;

   logic          w_out_valid;
   logic          w_consume;
   logic          w_underrun;
   logic          w_ack;
   logic          w_push;
   logic          w_issue;
   logic [CW-1:0] w_pop_cnt;
   logic [CW-1:0] w_push_cnt;
   logic [CW-1:0] w_count_after_pop;
   logic [PW-1:0] w_wr_idx [4];

   assign w_consume         = (r_state == ST_WAIT_CONSUME) && consume_valid;
   assign w_underrun        = CW'(consume_len) > r_count;
   assign w_pop_cnt         = w_consume ? (w_underrun ? r_count : CW'(consume_len)) : '0;
   assign w_count_after_pop = r_count - w_pop_cnt;
   assign w_ack             = r_fetch_req && fetch_ack;
   assign w_push            = w_ack && !r_drop_pending;
   assign w_push_cnt        = w_push ? CW'(3'd4 - {1'b0, r_skip}) : '0;
   // Bytes retired this cycle already count as free space for the next request.
   assign w_issue           = !r_fetch_req &&
                              ((CW'(DEPTH_BYTES) - w_count_after_pop) >= CW'(4));

   for (genvar gi = 0; gi < 4; gi++) begin : g_wr_idx
      assign w_wr_idx[gi] = r_wr_ptr + PW'(gi) - PW'(r_skip);
   end

   always_ff @(posedge clk) begin
      if (w_push && !flush && !rst) begin
         for (int k = 0; k < 4; k++) begin
            if (k >= int'(r_skip)) begin
               r_mem[w_wr_idx[k]] <= fetch_data[k*8 +: 8];
            end
         end
      end
   end

   assign valid_bytes = (r_count >= CW'(15)) ? 4'd15 : r_count[3:0];

   for (genvar gi = 0; gi < 15; gi++) begin : g_window
      logic [PW-1:0] w_rd_idx;
      assign w_rd_idx = r_rd_ptr + PW'(gi);
      assign bytes_out[gi*8 +: 8] = (4'(gi) < valid_bytes) ? r_mem[w_rd_idx] : 8'h00;
   end
   assign bytes_out[127:120] = 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + w_pop_cnt[PW-1:0];
         r_wr_ptr <= r_wr_ptr + w_push_cnt[PW-1:0];
         r_count  <= w_count_after_pop + w_push_cnt;
      end
   end

   // A request still in flight at flush is completed but its data is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_req    <= 1'b0;
         r_fetch_addr   <= {RESET_EIP[31:2], 2'b00};
         r_skip         <= RESET_EIP[1:0];
         r_drop_pending <= 1'b0;
      end else if (flush) begin
         r_fetch_req    <= r_fetch_req && !fetch_ack;
         r_drop_pending <= r_fetch_req && !fetch_ack;
         r_fetch_addr   <= {flush_eip[31:2], 2'b00};
         r_skip         <= flush_eip[1:0];
      end else if (w_ack) begin
         r_fetch_req <= 1'b0;
         if (r_drop_pending) begin
            r_drop_pending <= 1'b0;
         end else begin
            r_skip       <= 2'd0;
            r_fetch_addr <= r_fetch_addr + 32'd4;
         end
      end else if (w_issue) begin
         r_fetch_req <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_eip   <= RESET_EIP;
         r_underflow <= 1'b0;
      end else if (flush) begin
         r_out_eip   <= flush_eip;
         r_underflow <= 1'b0;
      end else if (w_consume) begin
         r_out_eip <= r_out_eip + 32'(consume_len);
         if (w_underrun) begin
            r_underflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_PRESENT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_out_valid  = 1'b0;
      case (r_state)
         ST_PRESENT: begin
            w_out_valid = (r_count >= CW'(MIN_WINDOW));
            if (w_out_valid && out_ready) begin
               w_state_next = ST_WAIT_CONSUME;
            end
         end
         ST_WAIT_CONSUME: begin
            if (consume_valid) begin
               w_state_next = ST_PRESENT;
            end
         end
         default: w_state_next = ST_PRESENT;
      endcase
      if (flush) begin
         w_state_next = ST_PRESENT;
      end
   end

   assign fetch_req     = r_fetch_req;
   assign fetch_addr    = r_fetch_addr;
   assign out_valid     = w_out_valid;
   assign out_eip       = r_out_eip;
   assign underflow_err = r_underflow;
endmodule
